// File: rtl/riscv_alu_mdu.sv
// rtl/riscv_alu_mdu.sv - integer ALU with iterative radix-2 multiply/divide behind a start/done handshake
module riscv_alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [SHW-1:0]    cnt;
    logic [4:0]        op_q;
    logic              sgn, neg_a, bzero;
    logic [2*XLEN-1:0] acc, mcand, prod_s;
    logic [XLEN-1:0]   opb, quo, rem;
    logic [XLEN-1:0]   alu_res, fix_res, mag_a, mag_b;
    logic [XLEN:0]     trial;
    logic              is_m, accept, last, a_signed, b_signed, sa, sb;

    assign is_m     = (op[4:3] == 2'b10);
    assign accept   = (state == IDLE) && start && !flush;
    assign last     = (cnt == SHW'(XLEN-1));
    assign a_signed = (op != 5'd19) && !(op[2] && op[0]);
    assign b_signed = (op[1:0] == 2'b00) || (op == 5'd17) || (op == 5'd22);
    assign sa       = a_signed && a[XLEN-1];
    assign sb       = b_signed && b[XLEN-1];
    assign mag_a    = sa ? (0 - a) : a;
    assign mag_b    = sb ? (0 - b) : b;
    // Restoring divide: quo shifts the dividend out of its top while quotient bits enter at the bottom
    assign trial    = {rem, quo[XLEN-1]} - {1'b0, opb};
    assign busy     = (state == MUL) || (state == DIV) || (state == FIX);

    always_comb begin
        alu_res = a;
        case (op)
            5'd0:    alu_res = a + b;
            5'd1:    alu_res = a << b[SHW-1:0];
            5'd2:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, a < b};
            5'd4:    alu_res = a ^ b;
            5'd5:    alu_res = a >> b[SHW-1:0];
            5'd6:    alu_res = a | b;
            5'd7:    alu_res = a & b;
            5'd8:    alu_res = a - b;
            5'd9:    alu_res = $signed(a) >>> b[SHW-1:0];
            5'd10:   alu_res = a;
            5'd11:   alu_res = b;
            5'd12:   alu_res = {{(XLEN-1){1'b0}}, a == b};
            default: alu_res = a;
        endcase
    end

    always_comb begin
        prod_s  = sgn ? (0 - acc) : acc;
        fix_res = prod_s[XLEN-1:0];
        case (op_q[2:0])
            3'd0:          fix_res = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fix_res = bzero ? {XLEN{1'b1}} : (sgn ? (0 - quo) : quo);
            default:       fix_res = neg_a ? (0 - rem) : rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_m) state_nxt = op[2] ? DIV : MUL;
            MUL,
            DIV:  if (flush)     state_nxt = IDLE;
                  else if (last) state_nxt = FIX;
            FIX:  state_nxt = flush ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op_q   <= '0;
            sgn    <= 1'b0;
            neg_a  <= 1'b0;
            bzero  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            quo    <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_m) begin
                        op_q  <= op;
                        sgn   <= sa ^ sb;
                        neg_a <= sa;
                        bzero <= (b == '0);
                        cnt   <= '0;
                        acc   <= '0;
                        rem   <= '0;
                        mcand <= {{XLEN{1'b0}}, mag_a};
                        opb   <= mag_b;
                        // quo holds the multiplier for MUL, the dividend for DIV
                        quo   <= op[2] ? mag_a : mag_b;
                    end else begin
                        result <= alu_res;
                        done   <= 1'b1;
                    end
                end
                MUL: begin
                    if (quo[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    quo   <= quo >> 1;
                    cnt   <= cnt + 1'b1;
                end
                DIV: begin
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: if (!flush) begin
                    result <= fix_res;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_alu_mdu.sv
// tb/tb_riscv_alu_mdu.sv - directed and randomized checks of riscv_alu_mdu against a behavioural model
module tb_riscv_alu_mdu;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, p;
        logic [63:0] up;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        up = {32'b0, x} * {32'b0, y};
        p  = 0;
        case (o)
            5'd0:  r = x + y;
            5'd1:  r = x << y[4:0];
            5'd2:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd3:  r = (x < y) ? 32'd1 : 32'd0;
            5'd4:  r = x ^ y;
            5'd5:  r = x >> y[4:0];
            5'd6:  r = x | y;
            5'd7:  r = x & y;
            5'd8:  r = x - y;
            5'd9:  r = $signed(x) >>> y[4:0];
            5'd11: r = y;
            5'd12: r = (x == y) ? 32'd1 : 32'd0;
            5'd16: begin p = sx * sy; r = p[31:0]; end
            5'd17: begin p = sx * sy; r = p[63:32]; end
            5'd18: begin p = sx * longint'({32'b0, y}); r = p[63:32]; end
            5'd19: r = up[63:32];
            5'd20: if (y == 0) r = 32'hFFFFFFFF;
                   else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
                   else begin p = sx / sy; r = p[31:0]; end
            5'd21: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            5'd22: if (y == 0) r = x;
                   else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 0;
                   else begin p = sx % sy; r = p[31:0]; end
            5'd23: r = (y == 0) ? x : x % y;
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Latency counts cycles from the start cycle to the cycle in which done is high
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
        if (!(o inside {[5'd16:5'd23]})) begin
            chk({tag, " done"}, {31'b0, done}, 32'd1);
            chk({tag, " busy"}, {31'b0, busy}, 32'd0);
            chk({tag, " result"}, result, exp);
        end else begin
            chk({tag, " busy"}, {31'b0, busy}, 32'd1);
            lat = 0;
            for (int k = 1; k <= 100 && lat == 0; k++) begin
                @(posedge clk); #1;
                if (done) lat = k + 1;
            end
            chk({tag, " latency"}, 32'(lat), 32'd34);
            chk({tag, " result"}, result, exp);
        end
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {31'b0, done}, 32'd0);
        chk({tag, " idle busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          seen;
        logic [4:0]  ro;
        logic [31:0] rx, ry;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(5'd0,  32'hFFFFFFFF, 32'h1,        "add wrap",     32'h00000000);
        run_op(5'd9,  32'h80000000, 32'h24,       "sra",          32'hF8000000);
        run_op(5'd3,  32'h1,        32'hFFFFFFFF, "sltu",         32'h1);
        run_op(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh",         32'h0);
        run_op(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul",          32'h1);
        run_op(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu",        32'hFFFFFFFE);
        run_op(5'd20, 32'h80000000, 32'hFFFFFFFF, "div ovf",      32'h80000000);
        run_op(5'd22, 32'h80000000, 32'hFFFFFFFF, "rem ovf",      32'h0);
        run_op(5'd21, 32'd7,        32'd0,        "divu by zero", 32'hFFFFFFFF);
        run_op(5'd23, 32'd7,        32'd0,        "remu by zero", 32'd7);
        run_op(5'd20, 32'hFFFFFFF9, 32'd2,        "div neg",      32'hFFFFFFFD);
        run_op(5'd22, 32'hFFFFFFF9, 32'd2,        "rem neg",      32'hFFFFFFFF);
        run_op(5'd20, 32'hFFFFFFF9, 32'd0,        "div by zero",  32'hFFFFFFFF);
        run_op(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu",       32'hFFFFFFFF);
        run_op(5'd15, 32'h1234,     32'h5678,     "bad op",       32'h1234);

        // Start ignored while busy, then flush mid-divide
        run_op(5'd0, 32'd5, 32'd5, "prior add", 32'd10);
        @(negedge clk); start = 1'b1; op = 5'd21; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
        @(posedge clk); #1; start = 1'b0;
        chk("start while busy: busy", {31'b0, busy}, 32'd1);
        chk("start while busy: done", {31'b0, done}, 32'd0);
        chk("start while busy: result", result, 32'd10);
        repeat (4) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush done", {31'b0, done}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("flush no done", 32'(seen), 32'd0);
        chk("flush result held", result, 32'd10);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk); start = 1'b1; op = 5'd16; a = 32'd3; b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        chk("async rst busy", {31'b0, busy}, 32'd0);
        chk("async rst done", {31'b0, done}, 32'd0);
        chk("async rst result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_op(5'd19, 32'h10000, 32'h10000, "mulhu after rst", 32'h1);

        for (int i = 0; i < 60; i++) begin
            ro = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(16, 23)) : 5'($urandom_range(0, 31));
            rx = rnd_val();
            ry = rnd_val();
            run_op(ro, rx, ry, $sformatf("rand op%0d a=%h b=%h", ro, rx, ry), ref_op(ro, rx, ry));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
